// File: rtl/press_count_blinker.sv
// press_count_blinker: replays a latched binary count as N blinks on one LED.
// The LED is lit for ON_CYCLES per blink and dark for OFF_CYCLES between blinks.
// A trailing dark period of GAP_CYCLES follows the last blink, then o_Done pulses.
// Optional feature macro: PRESS_BLINK_REPEAT_EN. It adds i_Repeat, which
// re-latches i_Count at the end of the gap so the LED keeps mirroring a live count.
module press_count_blinker #(
  parameter int WIDTH      = 4,
  parameter int ON_CYCLES  = 12500000,
  parameter int OFF_CYCLES = 12500000,
  parameter int GAP_CYCLES = 25000000
) (
  input  logic             CLK,
  input  logic             i_Reset,
  input  logic             i_Start,
  input  logic [WIDTH-1:0] i_Count,
`ifdef PRESS_BLINK_REPEAT_EN
  input  logic             i_Repeat,
`endif
  output logic             o_LED,
  output logic             o_Busy,
  output logic             o_Done
);

  // The timer holds at most (longest phase - 1), because it counts down to zero.
  localparam int MAX_AB = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int MAX_C  = (MAX_AB > GAP_CYCLES) ? MAX_AB : GAP_CYCLES;
  localparam int TW     = $clog2(MAX_C + 1);

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t           r_State;
  logic [TW-1:0]    r_Timer;
  logic [WIDTH-1:0] r_Remaining;
  logic             r_LED;
  logic             r_Busy;
  logic             r_Done;

  logic             w_TimerDone;
  logic [WIDTH-1:0] w_RemainingDec;
  logic             w_Repeat;

  assign w_TimerDone    = (r_Timer == '0);
  assign w_RemainingDec = r_Remaining - WIDTH'(1);

`ifdef PRESS_BLINK_REPEAT_EN
  assign w_Repeat = i_Repeat;
`else
  assign w_Repeat = 1'b0;
`endif

  assign o_LED  = r_LED;
  assign o_Busy = r_Busy;
  assign o_Done = r_Done;

  // Sequencer: state, per-phase down-timer, blinks remaining and registered outputs.
  always_ff @(posedge CLK or posedge i_Reset) begin
    if (i_Reset) begin
      r_State     <= S_IDLE;
      r_Timer     <= '0;
      r_Remaining <= '0;
      r_LED       <= 1'b0;
      r_Busy      <= 1'b0;
      r_Done      <= 1'b0;
    end else begin
      r_Done <= 1'b0;
      case (r_State)
        S_IDLE: begin
          if (i_Start) begin
            if (i_Count != '0) begin
              r_Remaining <= i_Count;
              r_Timer     <= ON_LOAD;
              r_State     <= S_ON;
              r_LED       <= 1'b1;
              r_Busy      <= 1'b1;
            end else begin
              // A zero-length request completes immediately without going busy.
              r_Done <= 1'b1;
            end
          end
        end
        S_ON: begin
          if (w_TimerDone) begin
            r_Remaining <= w_RemainingDec;
            r_LED       <= 1'b0;
            if (w_RemainingDec == '0) begin
              r_State <= S_GAP;
              r_Timer <= GAP_LOAD;
            end else begin
              r_State <= S_OFF;
              r_Timer <= OFF_LOAD;
            end
          end else begin
            r_Timer <= r_Timer - TW'(1);
          end
        end
        S_OFF: begin
          if (w_TimerDone) begin
            r_State <= S_ON;
            r_Timer <= ON_LOAD;
            r_LED   <= 1'b1;
          end else begin
            r_Timer <= r_Timer - TW'(1);
          end
        end
        S_GAP: begin
          if (w_TimerDone) begin
            r_Done <= 1'b1;
            if (w_Repeat && (i_Count != '0)) begin
              // Back-to-back sequence: busy never drops between them.
              r_Remaining <= i_Count;
              r_Timer     <= ON_LOAD;
              r_State     <= S_ON;
              r_LED       <= 1'b1;
            end else begin
              r_State <= S_IDLE;
              r_Timer <= '0;
              r_Busy  <= 1'b0;
            end
          end else begin
            r_Timer <= r_Timer - TW'(1);
          end
        end
        default: begin
          r_State <= S_IDLE;
          r_Timer <= '0;
          r_LED   <= 1'b0;
          r_Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_press_count_blinker.sv
// Testbench for press_count_blinker with short phases (ON=3, OFF=2, GAP=4).
// Expected waveforms come from closed-form arithmetic on the cycle offset
// since the accepting edge. Define PRESS_BLINK_REPEAT_EN to also exercise i_Repeat.
module tb_press_count_blinker;

  localparam int W   = 4;
  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int GAP = 4;
  localparam int P   = ON + OFF;

  logic         CLK = 1'b0;
  logic         i_Reset = 1'b1;
  logic         i_Start = 1'b0;
  logic [W-1:0] i_Count = '0;
`ifdef PRESS_BLINK_REPEAT_EN
  logic         i_Repeat = 1'b0;
`endif
  logic         o_LED;
  logic         o_Busy;
  logic         o_Done;

  int checks = 0;
  int errors = 0;

  press_count_blinker #(
    .WIDTH      (W),
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF),
    .GAP_CYCLES (GAP)
  ) dut (
    .CLK      (CLK),
    .i_Reset  (i_Reset),
    .i_Start  (i_Start),
    .i_Count  (i_Count),
`ifdef PRESS_BLINK_REPEAT_EN
    .i_Repeat (i_Repeat),
`endif
    .o_LED    (o_LED),
    .o_Busy   (o_Busy),
    .o_Done   (o_Done)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic led, input logic busy, input logic done);
    check({tag, " led"}, 32'(o_LED), 32'(led));
    check({tag, " busy"}, 32'(o_Busy), 32'(busy));
    check({tag, " done"}, 32'(o_Done), 32'(done));
  endtask

  // Busy length for n blinks.
  function automatic int seq_len(input int n);
    return n * ON + (n - 1) * OFF + GAP;
  endfunction

  // LED level t cycles after the accepting edge: lit in the first ON cycles of
  // each ON+OFF period, and dark once the last blink has finished.
  function automatic logic m_led(input int n, input int t);
    return (t < n * P - OFF) && ((t % P) < ON);
  endfunction

  task automatic idle_cycles(input int k, input string tag);
    i_Start = 1'b0;
    for (int i = 0; i < k; i++) begin
      tick();
      check_out(tag, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // mode 0: quiet inputs; 1: random i_Start/i_Count noise while busy;
  // 2: a start request with count 9 during the first OFF phase.
  task automatic run_seq(input int n, input int mode);
    int len;
    i_Count = 4'(n);
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    if (n == 0) begin
      check_out("zero_accept", 1'b0, 1'b0, 1'b1);
      tick();
      check_out("zero_after", 1'b0, 1'b0, 1'b0);
      $display("seq n=0 mode=%0d zero-length request", mode);
      return;
    end
    len = seq_len(n);
    for (int t = 0; t <= len; t++) begin
      check_out($sformatf("seq n=%0d t=%0d", n, t), m_led(n, t), t < len, t == len);
      if (mode == 1 && t < len) begin
        i_Count = 4'($urandom);
        i_Start = 1'($urandom_range(0, 1));
      end else if (mode == 2 && t == ON) begin
        i_Count = 4'd9;
        i_Start = 1'b1;
      end else begin
        i_Start = 1'b0;
      end
      if (t < len) tick();
    end
    i_Start = 1'b0;
    tick();
    check_out($sformatf("seq n=%0d post", n), 1'b0, 1'b0, 1'b0);
    $display("seq n=%0d mode=%0d busy_len=%0d", n, mode, len);
  endtask

  initial begin
    int len;

    // Reset state, then quiet idle after release.
    tick();
    check_out("in_reset", 1'b0, 1'b0, 1'b0);
    tick();
    i_Reset = 1'b0;
    idle_cycles(20, "idle_after_reset");
    $display("reset/idle 20 cycles");

    // Directed sequences.
    run_seq(3, 0);
    idle_cycles(2, "gap_idle");
    run_seq(0, 0);
    idle_cycles(2, "gap_idle");
    run_seq(2, 2);
    idle_cycles(2, "gap_idle");

    // Level-sensitive restart: start held high through done.
    len = seq_len(1);
    i_Count = 4'd1;
    i_Start = 1'b1;
    tick();
    for (int t = 0; t <= len; t++) begin
      check_out($sformatf("held t=%0d", t), m_led(1, t), t < len, t == len);
      if (t < len) tick();
    end
    tick();
    i_Start = 1'b0;
    check_out("held_restart", 1'b1, 1'b1, 1'b0);
    for (int t = 1; t <= len; t++) begin
      tick();
      check_out($sformatf("held2 t=%0d", t), m_led(1, t), t < len, t == len);
    end
    $display("held start restart n=1");
    idle_cycles(2, "gap_idle");

    // Abort during the second blink with an asynchronous reset.
    i_Count = 4'd15;
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    for (int t = 1; t <= P + 1; t++) tick();
    check_out("pre_abort", 1'b1, 1'b1, 1'b0);
    #2;
    i_Reset = 1'b1;
    #1;
    check_out("async_abort", 1'b0, 1'b0, 1'b0);
    tick();
    check_out("abort_held", 1'b0, 1'b0, 1'b0);
    i_Reset = 1'b0;
    idle_cycles(10, "post_abort_idle");
    $display("abort during 2nd blink n=15");
    run_seq(15, 0);

    // Randomised sequences with noise on the inputs while busy.
    for (int k = 0; k < 12; k++) begin
      idle_cycles($urandom_range(0, 3), "rand_idle");
      run_seq($urandom_range(0, 15), 1);
    end

`ifdef PRESS_BLINK_REPEAT_EN
    // Repeat mode: count re-latched at the end of the gap.
    idle_cycles(2, "gap_idle");
    i_Repeat = 1'b1;
    i_Count  = 4'd1;
    i_Start  = 1'b1;
    tick();
    i_Start = 1'b0;
    len = seq_len(1);
    for (int t = 0; t < len; t++) begin
      check_out($sformatf("rep1 t=%0d", t), m_led(1, t), 1'b1, 1'b0);
      if (t == ON) i_Count = 4'd2;
      tick();
    end
    check_out("repeat_exit", 1'b1, 1'b1, 1'b1);
    i_Repeat = 1'b0;
    len = seq_len(2);
    for (int t = 1; t <= len; t++) begin
      tick();
      check_out($sformatf("rep2 t=%0d", t), m_led(2, t), t < len, t == len);
    end
    idle_cycles(3, "rep_idle");
    $display("repeat 1 then 2 blinks");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/press_count_blinker.md
Name: press_count_blinker

Overview:
- Encoder counterpart to the press counter: converts a latched binary count back into a train of visible LED blinks, one blink per unit of count.
- Sits beside the counter and LED outputs so a user can read the count as N flashes on a single LED.
- Start/busy/done handshake to its driver.
- Fully synchronous to CLK apart from the reset.

Parameters:
- WIDTH, 4, width of i_Count; the maximum blink count is 2^WIDTH-1.
- ON_CYCLES, 12500000, CLK cycles the LED is lit per blink (>=1).
- OFF_CYCLES, 12500000, CLK cycles the LED is dark between blinks (>=1).
- GAP_CYCLES, 25000000, CLK cycles the LED is dark after the last blink, before done (>=1).

Ports:
- CLK  input  1  system clock, all state on rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Start  input  1  request; sampled only in IDLE.
- i_Count  input  WIDTH  number of blinks; latched on the accepting edge.
- o_LED  output  1  blink output, registered.
- o_Busy  output  1  high while a blink sequence is in progress.
- o_Done  output  1  one-cycle pulse when a sequence completes.

Behaviour:
- One clock domain: CLK. Reset i_Reset is asynchronous and active-high.
- Reset forces state IDLE and o_LED=0, o_Busy=0, o_Done=0, and clears the remaining-count and timer registers. It acts immediately, including mid-sequence. No o_Done is produced for an aborted sequence.
- FSM states: IDLE, ON, OFF, GAP. A timer counts the cycles spent in each state. A remaining-count register of WIDTH bits tracks blinks left.
- IDLE with i_Start=1 and i_Count!=0, on the sampling edge:
  - latch i_Count into remaining;
  - enter ON;
  - set o_LED=1 and o_Busy=1 at that same edge.
- IDLE with i_Start=1 and i_Count=0: stay IDLE, o_Busy stays 0, and o_Done=1 for exactly one cycle from that edge.
- ON: o_LED=1 for exactly ON_CYCLES cycles. Then decrement remaining.
  - If the new value is 0, go to GAP.
  - Otherwise go to OFF.
- OFF: o_LED=0 for exactly OFF_CYCLES cycles, then return to ON.
- GAP: o_LED=0 for exactly GAP_CYCLES cycles. On the exit edge:
  - o_Busy falls;
  - o_Done=1 for one cycle;
  - state returns to IDLE.
- o_Busy duration = N*ON_CYCLES + (N-1)*OFF_CYCLES + GAP_CYCLES cycles for latched count N.
- i_Start while o_Busy=1 is ignored, with no queuing. i_Count changes after latching are ignored.
- i_Start held high continuously restarts a new sequence on the first IDLE cycle after o_Done. Restart is level-sensitive, not edge-sensitive.
- Timer width is sized for max(ON_CYCLES, OFF_CYCLES, GAP_CYCLES). The timer reloads on every state entry. Timer wrap never occurs.

Optional Feature:
- Macro PRESS_BLINK_REPEAT_EN.
- Defined:
  - adds input port i_Repeat (1 bit);
  - at GAP exit, if i_Repeat=1, o_Done still pulses for one cycle;
  - i_Count is re-latched at that edge; if nonzero, the FSM enters ON directly with o_Busy held high;
  - if the re-latched i_Count is 0, the FSM returns to IDLE;
  - this lets the LED continuously mirror a live counter.
- Undefined: no i_Repeat port; behaviour is one-shot exactly as above.

Test Plan (ON_CYCLES=3, OFF_CYCLES=2, GAP_CYCLES=4, WIDTH=4):
1. Assert i_Reset, then release with i_Start=0 -> o_LED=0, o_Busy=0, o_Done=0 for 20 cycles.
2. i_Count=3, one-cycle i_Start -> o_LED pattern 1,1,1,0,0,1,1,1,0,0,1,1,1,0,0,0,0. o_Busy high for 17 cycles. o_Done high for exactly 1 cycle on the edge o_Busy falls.
3. i_Count=0, one-cycle i_Start -> o_LED stays 0, o_Busy stays 0, o_Done high for 1 cycle starting at the sampling edge.
4. Start with i_Count=2, then pulse i_Start with i_Count=9 during the first OFF -> exactly 2 blinks, o_Busy 12 cycles, a single o_Done.
5. i_Count=15 start, then assert i_Reset during the 2nd ON -> o_LED and o_Busy drop asynchronously, no o_Done. After release, stays IDLE. A new start with i_Count=15 gives 15 blinks and o_Busy=77 cycles.
6. With PRESS_BLINK_REPEAT_EN and i_Repeat=1: start with i_Count=1, change i_Count to 2 during GAP -> o_Done pulse, o_Busy stays high, then 2 blinks follow immediately. Drop i_Repeat -> IDLE after the second GAP.
